// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing a single 256x8 memory bank among NUM_REQ requesters.
// One request is served at a time: IDLE -> ACCESS -> DONE, with a one-cycle Ack in DONE.
module mem_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [NUM_REQ-1:0]   We,
  input  logic [8*NUM_REQ-1:0] Addr,
  input  logic [8*NUM_REQ-1:0] WData,
  output logic [NUM_REQ-1:0]   Ack,
  output logic [7:0]           RData,
  output logic                 Busy,
  output logic [7:0]           MemAddr,
  output logic [7:0]           MemWData,
  output logic                 MemWrite,
  output logic                 MemRead,
  input  logic [7:0]           MemRData
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [ID_W-1:0] r_ptr, r_id;
  logic            r_we;
  logic [7:0]      r_addr, r_wdata, r_rdata;

  logic            w_any;
  logic [ID_W-1:0] w_win, w_ptr_next;
  logic            w_sel_we;
  logic [7:0]      w_sel_addr, w_sel_wdata;

  // Scan offsets from the highest down so the smallest offset from r_ptr wins.
  always_comb begin
    w_any = |Req;
    w_win = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (Req[i] && (i == (32'(r_ptr) + k - 1) % NUM_REQ))
          w_win = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_win) begin
        w_sel_we    = We[i];
        w_sel_addr  = Addr[8*i +: 8];
        w_sel_wdata = WData[8*i +: 8];
      end
    end
  end

  assign w_ptr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_id    <= w_win;
          r_we    <= w_sel_we;
          r_addr  <= w_sel_addr;
          r_wdata <= w_sel_wdata;
        end
        S_ACCESS: if (!r_we) r_rdata <= MemRData;
        S_DONE:   r_ptr <= w_ptr_next;
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Ack      = '0;
    Busy     = (r_state != S_IDLE);
    MemAddr  = '0;
    MemWData = '0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    if (r_state == S_ACCESS) begin
      MemAddr  = r_addr;
      MemWData = r_wdata;
      MemWrite = r_we & ~Reset;
      MemRead  = ~r_we;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_state == S_DONE && ID_W'(i) == r_id)
        Ack[i] = 1'b1;
    end
  end

  assign RData = r_rdata;

endmodule
